if_prefetch: RTL
================

// Module: if_prefetch
// PURPOSE
//   Instruction-fetch front end of the pipelined CPU. Drives the PC into the combinational instruction
//   memory, captures {pc, instr} pairs into a small prefetch queue, and presents them to the decode
//   stage over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and
//   restart fetch at the new target.
// PARAMETERS
//   DEPTH     4             queue entries; power of two, >= 2
//   RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//   clk          in   1   CPU clock; all state on rising edge
//   reset        in   1   asynchronous, active-high reset
//   imem_pc      out  32  fetch address to instruction memory (im uses imem_pc[8:2])
//   imem_instr   in   32  instruction word; combinational, valid in the same cycle as imem_pc
//   redirect     in   1   flush queue and restart fetch at redirect_pc
//   redirect_pc  in   32  new fetch address; bits [1:0] ignored (treated as 00)
//   out_valid    out  1   head entry valid
//   out_ready    in   1   decode accepts head this cycle
//   out_pc       out  32  PC of head entry
//   out_instr    out  32  instruction of head entry
//   count        out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - State: fetch_pc reg, DEPTH-entry storage of {pc, instr}, rd_ptr/wr_ptr (log2 DEPTH, wrap mod DEPTH),
//     count reg. No other FSM; occupancy-driven.
//   - imem_pc = fetch_pc, driven straight from the register.
//   - pop = out_valid & out_ready & ~redirect.
//   - push = ~redirect & (count < DEPTH | pop); a full queue pushes in the same cycle it pops.
//   - On push: entry[wr_ptr] <= {fetch_pc, imem_instr}; wr_ptr++; fetch_pc <= fetch_pc + 4
//     (32-bit wrap, carry discarded).
//   - On pop: rd_ptr++. count <= count + push - pop.
//   - out_valid = (count != 0); out_pc/out_instr = entry[rd_ptr], driven from registers only.
//     Data is don't-care when out_valid=0.
//   - Latency: a word fetched in cycle N is visible at the head in cycle N+1 if the queue was empty.
//   - Redirect (highest priority): at the edge, count<=0, rd_ptr<=wr_ptr<=0,
//     fetch_pc <= {redirect_pc[31:2],2'b00}. No push and no pop that cycle; a head shown with
//     out_ready=1 during redirect is not consumed and is discarded. First new word appears at the
//     head two cycles after the redirect cycle (fetch in N+1, valid in N+2).
//   - Back-to-back redirects: the later one wins; the queue stays empty until one cycle after the
//     last redirect.
//   - Full (count==DEPTH) and no pop: fetch_pc holds, no write, storage unchanged.
//   - Empty: out_valid=0; out_ready is ignored.
//   - Reset (async, any time incl. mid-stream): fetch_pc<=RESET_PC, count<=0, ptrs<=0, out_valid=0,
//     imem_pc=RESET_PC, count=0. Storage contents need not be reset. After reset deasserts, the first
//     push happens on the first clock edge.
// TESTING
//   1. Reset, out_ready=1 forever, im holds addi sequence -> out_valid=1 from cycle 1; out_pc 0,4,8,...;
//      one instr per cycle; count stays 1.
//   2. out_ready=0 for 10 cycles -> count rises 1..4 then holds at 4; imem_pc holds 0x10; release ->
//      pops 0,4,8,C with no gap, then 0x10 follows.
//   3. Queue full, out_ready=1 -> each cycle simultaneous push/pop, count stays 4, PCs strictly +4.
//   4. redirect=1, redirect_pc=0x43 while count=3 -> next cycle count=0, out_valid=0, imem_pc=0x40;
//      cycle after that out_pc=0x40 with im[0x10] data.
//   5. redirect on two consecutive cycles (0x20 then 0x80) -> first valid head is 0x80; no 0x20 entry is
//      ever presented.
//   6. Assert reset mid-stream with count=2 -> out_valid and count drop to 0 asynchronously before the next
//      edge; imem_pc=RESET_PC; after release, stream restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: drives imem_pc and queues fetched {pc, instr}
// pairs in a DEPTH-entry FIFO, which decode drains over out_valid/out_ready.
// Ports: clk, reset (async, active high); imem_pc/imem_instr (instruction
//   memory); redirect/redirect_pc (flush and restart); out_valid, out_ready,
//   out_pc, out_instr (head entry handshake to decode); count (occupancy).
module if_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [31:0]                imem_pc,
   input  logic [31:0]                imem_instr,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   entry_pc_q    [DEPTH];
   logic [31:0]   entry_instr_q [DEPTH];

   logic          push;
   logic          pop;

   assign imem_pc   = fetch_pc_q;
   assign count     = count_q;
   assign out_valid = (count_q != '0);
   assign out_pc    = entry_pc_q[rd_ptr_q];
   assign out_instr = entry_instr_q[rd_ptr_q];

   always_comb begin
      pop  = out_valid & out_ready & ~redirect;
      // A full queue may still accept a word when the head leaves this cycle.
      push = ~redirect & ((count_q < CW'(DEPTH)) | pop);

      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         entry_pc_q[wr_ptr_q]    <= fetch_pc_q;
         entry_instr_q[wr_ptr_q] <= imem_instr;
      end
   end

endmodule
